core_dmem_responder: RTL and testbench

//  Responder (memory side) of the core data memory bus: accepts dmem_req/addr/wen/strb/wdata

---
 rtl/core_dmem_responder_pkg.sv | 34 +++
 rtl/core_dmem_responder_sram.sv | 32 +++
 rtl/core_dmem_responder.sv | 117 +++++++++++
 tb/tb_core_dmem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/core_dmem_responder_pkg.sv
// Shared constants, FSM state and latched-request layout for the core data memory responder.
// Bus widths match the LSU side of the dmem interface.
package core_dmem_responder_pkg;

    localparam int MEM_ADDR_R = 64;
    localparam int MEM_DATA_R = 64;
    localparam int MEM_STRB_R = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Request fields captured at accept; the error verdict is frozen here as well.
    typedef struct packed {
        logic                  wen;
        logic                  err;
        logic [MEM_STRB_R-1:0] strb;
        logic [MEM_DATA_R-1:0] wdata;
    } dmem_lat_t;

    // off is addr-base; the addr<base term covers the underflowed case.
    function automatic logic dmem_addr_err(
        input logic [MEM_ADDR_R-1:0] addr,
        input logic [MEM_ADDR_R-1:0] off,
        input logic [MEM_ADDR_R-1:0] base,
        input logic [MEM_ADDR_R-1:0] span
    );
        return (addr < base) || (off >= span) || (addr[2:0] != 3'b000);
    endfunction

endpackage

// File: rtl/core_dmem_responder_sram.sv
// Single-port DEPTH x 64 SRAM with per-byte write enables and a registered read port.
// Contents are not reset; rdata holds its value until the next read.
module core_sram_1rw
    import core_dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                  g_clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [MEM_STRB_R-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [MEM_DATA_R-1:0] wdata,
    output logic [MEM_DATA_R-1:0] rdata
);

    logic [MEM_DATA_R-1:0] mem [DEPTH];

    always_ff @(posedge g_clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < MEM_STRB_R; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/core_dmem_responder.sv
// Memory-side responder of the core dmem bus: SRAM-backed, programmable wait states,
// stall hook, registered gnt/err/rdata and bus-error detection at request accept.
module core_dmem_responder
    import core_dmem_responder_pkg::*;
#(
    parameter int unsigned           DEPTH       = 1024,
    parameter logic [MEM_ADDR_R-1:0] BASE_ADDR   = 64'h20000,
    parameter int unsigned           WAIT_CYCLES = 0
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  dmem_req,
    input  logic [MEM_ADDR_R-1:0] dmem_addr,
    input  logic                  dmem_wen,
    input  logic [MEM_STRB_R-1:0] dmem_strb,
    input  logic [MEM_DATA_R-1:0] dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_err,
    output logic [MEM_DATA_R-1:0] dmem_rdata,
    input  logic                  stall
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_ADDR_R-1:0] SPAN = MEM_ADDR_R'(DEPTH) << 3;

    dmem_state_t           state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    dmem_lat_t             req_q;
    logic [AW-1:0]         idx_q;

    logic [MEM_ADDR_R-1:0] off;
    logic [AW-1:0]         in_idx;
    logic                  in_err;
    logic                  accept, commit;
    logic                  sram_en, sram_we;
    logic [AW-1:0]         sram_addr;
    logic [MEM_DATA_R-1:0] sram_rdata;

    assign off    = dmem_addr - BASE_ADDR;
    assign in_idx = off[AW+2:3];
    assign in_err = dmem_addr_err(dmem_addr, off, BASE_ADDR, SPAN);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // A dropped request in WAIT abandons the access before any write or grant.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (dmem_req) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!dmem_req)                   state_nxt = ST_IDLE;
                else if (!stall && cnt == '0)    state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reads are issued at accept so data sits in the SRAM register during WAIT;
    // writes land on the WAIT->RESP edge.
    always_comb begin
        accept    = (state == ST_IDLE) && dmem_req;
        commit    = (state == ST_WAIT) && dmem_req && !stall && (cnt == '0);
        sram_en   = (accept && !dmem_wen && !in_err) || (commit && req_q.wen && !req_q.err);
        sram_we   = (state == ST_WAIT);
        sram_addr = (state == ST_IDLE) ? in_idx : idx_q;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt   <= '0;
            req_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            cnt   <= CNT_W'(WAIT_CYCLES);
            req_q <= '{wen: dmem_wen, err: in_err, strb: dmem_strb, wdata: dmem_wdata};
            idx_q <= in_idx;
        end else if ((state == ST_WAIT) && dmem_req && !stall && (cnt != '0)) begin
            cnt   <= cnt - 1'b1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            dmem_gnt   <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            dmem_gnt   <= commit;
            dmem_err   <= commit && req_q.err;
            dmem_rdata <= (commit && !req_q.wen && !req_q.err) ? sram_rdata : '0;
        end
    end

    core_sram_1rw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .g_clk (g_clk),
        .en    (sram_en),
        .we    (sram_we),
        .be    (req_q.strb),
        .addr  (sram_addr),
        .wdata (req_q.wdata),
        .rdata (sram_rdata)
    );

`ifndef SYNTHESIS
    a_req_held_in_wait: assert property (
        @(posedge g_clk) disable iff (!g_resetn) (state == ST_WAIT) |-> dmem_req
    );
`endif

endmodule

// File: tb/tb_core_dmem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) share one muxed request bus;
// stimulus queues expected responses, a negedge monitor checks every gnt.
module tb_core_dmem_responder;

    localparam logic [63:0] BASE = 64'h20000;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        req = 1'b0, sel = 1'b0, wen = 1'b0, stall = 1'b0;
    logic [63:0] addr = '0, wdata = '0;
    logic [7:0]  strb = '0;

    logic        gnt_a, err_a, gnt_b, err_b, gnt, err;
    logic [63:0] rdata_a, rdata_b, rdata;

    assign gnt   = gnt_a | gnt_b;
    assign err   = gnt_b ? err_b : err_a;
    assign rdata = gnt_b ? rdata_b : rdata_a;

    core_dmem_responder #(.DEPTH(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_a (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem_req(req && !sel), .dmem_addr(addr),
        .dmem_wen(wen), .dmem_strb(strb), .dmem_wdata(wdata), .dmem_gnt(gnt_a),
        .dmem_err(err_a), .dmem_rdata(rdata_a), .stall(stall));

    core_dmem_responder #(.DEPTH(16), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut_b (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem_req(req && sel), .dmem_addr(addr),
        .dmem_wen(wen), .dmem_strb(strb), .dmem_wdata(wdata), .dmem_gnt(gnt_b),
        .dmem_err(err_b), .dmem_rdata(rdata_b), .stall(stall));

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc++;

    typedef struct {
        bit          err;
        bit          chk_rd;
        logic [63:0] rd;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s tag=%0d: got %h want %h", nm, tag, act, exp);
    endtask

    always @(negedge g_clk) begin
        if (g_resetn && gnt) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_gnt at cycle %0d: got gnt=1 want no gnt", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("gnt_cycle", x.tag, 64'(cyc), 64'(x.cyc));
                chk("err", x.tag, 64'(err), 64'(x.err));
                if (x.chk_rd) chk("rdata", x.tag, rdata, x.rd);
            end
        end
    end

    task automatic wait_gnt(input int tag);
        int n;
        n = 0;
        do begin
            @(negedge g_clk);
            n++;
        end while (!gnt && n < 50);
        if (!gnt) begin
            checks++;
            $display("FAIL gnt_timeout tag=%0d: got no gnt in %0d cycles want gnt", tag, n);
        end
    endtask

    task automatic push(input bit e, input bit chk_rd, input logic [63:0] rd, input int lat, input int tag);
        exp_t x;
        x.err = e; x.chk_rd = chk_rd; x.rd = rd; x.cyc = cyc + lat; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic access(input bit w, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                          input bit e, input logic [63:0] rd, input int lat, input int tag);
        @(negedge g_clk);
        push(e, !w, rd, lat, tag);
        wen = w; addr = a; strb = s; wdata = d; req = 1'b1;
        wait_gnt(tag);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("rst_gnt_a", 0, 64'(gnt_a), 64'd0);
        chk("rst_err_a", 0, 64'(err_a), 64'd0);
        chk("rst_rdata_a", 0, rdata_a, 64'd0);
        chk("rst_gnt_b", 0, 64'(gnt_b), 64'd0);
        repeat (3) @(negedge g_clk);
        g_resetn = 1'b1;

        // zero wait states
        sel = 1'b0;
        access(1, BASE, 8'hFF, 64'h1122334455667788, 0, '0, 2, 1);
        access(0, BASE, 8'h00, '0, 0, 64'h1122334455667788, 2, 2);
        access(1, BASE, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0, '0, 2, 3);
        access(0, BASE, 8'h00, '0, 0, 64'h11223344BBBBBBBB, 2, 4);
        access(0, BASE + 64'h2000, 8'h00, '0, 1, '0, 2, 5);
        access(0, BASE + 64'h4, 8'h00, '0, 1, '0, 2, 6);
        access(1, BASE + 64'h4, 8'hFF, 64'h0, 1, '0, 2, 7);
        access(1, BASE - 64'h8, 8'hFF, 64'h0, 1, '0, 2, 8);
        access(0, BASE, 8'h00, '0, 0, 64'h11223344BBBBBBBB, 2, 9);
        access(1, BASE + 64'h1FF8, 8'hFF, 64'hCAFEF00DDEADBEEF, 0, '0, 2, 10);
        access(1, BASE + 64'h1FF8, 8'h00, 64'h0, 0, '0, 2, 11);
        access(0, BASE + 64'h1FF8, 8'h00, '0, 0, 64'hCAFEF00DDEADBEEF, 2, 12);

        // request held through gnt: two reads three cycles apart
        @(negedge g_clk);
        push(0, 1, 64'h11223344BBBBBBBB, 2, 13);
        push(0, 1, 64'h11223344BBBBBBBB, 5, 14);
        wen = 1'b0; addr = BASE; strb = '0; req = 1'b1;
        wait_gnt(13);
        wait_gnt(14);
        req = 1'b0;

        // three wait states
        sel = 1'b1;
        access(1, BASE, 8'hFF, 64'h0123456789ABCDEF, 0, '0, 5, 20);
        fork
            access(0, BASE, 8'h00, '0, 0, 64'h0123456789ABCDEF, 7, 21);
            begin
                repeat (2) @(negedge g_clk);
                stall = 1'b1;
                repeat (2) @(negedge g_clk);
                stall = 1'b0;
            end
        join
        access(0, BASE + 64'h80, 8'h00, '0, 1, '0, 5, 22);

        // reset in the middle of a write's wait period
        @(negedge g_clk);
        wen = 1'b1; addr = BASE; strb = 8'hFF; wdata = '1; req = 1'b1;
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b0;
        #1;
        chk("midrst_gnt_b", 30, 64'(gnt_b), 64'd0);
        chk("midrst_err_b", 30, 64'(err_b), 64'd0);
        chk("midrst_rdata_b", 30, rdata_b, 64'd0);
        req = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        access(0, BASE, 8'h00, '0, 0, 64'h0123456789ABCDEF, 5, 31);
        sel = 1'b0;
        access(0, BASE, 8'h00, '0, 0, 64'h11223344BBBBBBBB, 2, 32);

        repeat (10) @(negedge g_clk);
        chk("sb_empty", 99, 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
